// File: rtl/pong_game_sequencer.sv
// Game-level sequencer for the tennis datapath: serve/rally/lost/game-over flow, move strobe, lives and score.
// Define PONG_SCORE_BCD_EN to report score as two packed BCD digits instead of saturating binary.
module pong_game_sequencer #(
    parameter int unsigned LIVES            = 3,
    parameter int unsigned SERVE_FRAMES     = 60,
    parameter int unsigned LOST_FRAMES      = 90,
    parameter int unsigned STEP_PERIOD_INIT = 131071,
    parameter int unsigned STEP_PERIOD_MIN  = 32767,
    parameter int unsigned STEP_DEC         = 8192,
    parameter int unsigned SPEEDUP_HITS     = 4
) (
    input  logic       reset,
    input  logic       pixelClock,
    input  logic       vSync,
    input  logic       startBtn,
    input  logic       pauseBtn,
    input  logic       ballHit,
    input  logic       ballMiss,
    output logic       moveStb,
    output logic       ballCenter,
    output logic [2:0] gameState,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       gameOver
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        LOST      = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [16:0] PERIOD_INIT = 17'(STEP_PERIOD_INIT);
    localparam logic [16:0] PERIOD_MIN  = 17'(STEP_PERIOD_MIN);
    localparam logic [16:0] PERIOD_DEC  = 17'(STEP_DEC);
    localparam logic [17:0] DEC_FLOOR   = 18'(STEP_PERIOD_MIN) + 18'(STEP_DEC);
    localparam logic [7:0]  SERVE_CNT   = 8'(SERVE_FRAMES);
    localparam logic [7:0]  LOST_CNT    = 8'(LOST_FRAMES);
    localparam logic [3:0]  HIT_CNT     = 4'(SPEEDUP_HITS);
    localparam logic [1:0]  LIVES_INIT  = 2'(LIVES);

    logic [1:0]  start_sync_q, start_sync_d;
    logic        start_prev_q, start_prev_d;
    logic [1:0]  pause_sync_q, pause_sync_d;
    logic        pause_prev_q, pause_prev_d;
    logic        vsync_prev_q, vsync_prev_d;
    state_t      state_q, state_d;
    logic        move_stb_q, move_stb_d;
    logic        ball_center_q, ball_center_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  score_q, score_d;
    logic        game_over_q, game_over_d;
    logic [16:0] step_period_q, step_period_d;
    logic [16:0] step_cnt_q, step_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  hit_cnt_q, hit_cnt_d;

    logic start_ev, pause_ev, frame_tick;
    logic new_game, step_run, step_wrap;

    function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef PONG_SCORE_BCD_EN
        if (s == 8'h99) return s;
        if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
`else
        return (s == 8'hFF) ? s : s + 8'd1;
`endif
    endfunction

    assign start_ev   = start_sync_q[1] & ~start_prev_q;
    assign pause_ev   = pause_sync_q[1] & ~pause_prev_q;
    assign frame_tick = vsync_prev_q & ~vSync;
    // cnt+1 >= period also recovers cleanly when a speed-up shrinks the period below the running count
    assign step_wrap  = ({1'b0, step_cnt_q} + 18'd1) >= {1'b0, step_period_q};

    always_comb begin
        start_sync_d  = {start_sync_q[0], startBtn};
        start_prev_d  = start_sync_q[1];
        pause_sync_d  = {pause_sync_q[0], pauseBtn};
        pause_prev_d  = pause_sync_q[1];
        vsync_prev_d  = vSync;
        state_d       = state_q;
        move_stb_d    = 1'b0;
        ball_center_d = 1'b0;
        lives_d       = lives_q;
        score_d       = score_q;
        step_period_d = step_period_q;
        step_cnt_d    = step_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        new_game      = 1'b0;
        step_run      = 1'b0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_ev) new_game = 1'b1;
            end
            SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q + 8'd1 >= SERVE_CNT) begin
                        state_d     = PLAY;
                        frame_cnt_d = '0;
                        step_cnt_d  = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                // miss beats hit beats pause; leaving PLAY freezes the step counter
                if (ballMiss) begin
                    state_d = LOST;
                    if (lives_q != '0) lives_d = lives_q - 2'd1;
                end else if (pause_ev && !ballHit) begin
                    state_d = PAUSE;
                end else begin
                    step_run = 1'b1;
                    if (ballHit) begin
                        score_d = score_inc(score_q);
                        if (hit_cnt_q + 4'd1 >= HIT_CNT) begin
                            hit_cnt_d     = '0;
                            step_period_d = ({1'b0, step_period_q} >= DEC_FLOOR) ?
                                            step_period_q - PERIOD_DEC : PERIOD_MIN;
                        end else begin
                            hit_cnt_d = hit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            PAUSE: begin
                if (pause_ev) state_d = PLAY;
            end
            LOST: begin
                if (lives_q == '0) begin
                    state_d = GAME_OVER;
                end else if (frame_tick) begin
                    if (frame_cnt_q + 8'd1 >= LOST_CNT) begin
                        state_d       = SERVE;
                        frame_cnt_d   = '0;
                        ball_center_d = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (step_run) begin
            if (step_wrap) begin
                move_stb_d = 1'b1;
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + 17'd1;
            end
        end

        if (new_game) begin
            state_d       = SERVE;
            lives_d       = LIVES_INIT;
            score_d       = '0;
            hit_cnt_d     = '0;
            step_period_d = PERIOD_INIT;
            frame_cnt_d   = '0;
            ball_center_d = 1'b1;
        end

        game_over_d = (state_d == GAME_OVER);
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            start_sync_q  <= '0;
            start_prev_q  <= 1'b0;
            pause_sync_q  <= '0;
            pause_prev_q  <= 1'b0;
            vsync_prev_q  <= 1'b0;
            state_q       <= IDLE;
            move_stb_q    <= 1'b0;
            ball_center_q <= 1'b0;
            lives_q       <= '0;
            score_q       <= '0;
            game_over_q   <= 1'b0;
            step_period_q <= PERIOD_INIT;
            step_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            hit_cnt_q     <= '0;
        end else begin
            start_sync_q  <= start_sync_d;
            start_prev_q  <= start_prev_d;
            pause_sync_q  <= pause_sync_d;
            pause_prev_q  <= pause_prev_d;
            vsync_prev_q  <= vsync_prev_d;
            state_q       <= state_d;
            move_stb_q    <= move_stb_d;
            ball_center_q <= ball_center_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            game_over_q   <= game_over_d;
            step_period_q <= step_period_d;
            step_cnt_q    <= step_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
        end
    end

    assign moveStb    = move_stb_q;
    assign ballCenter = ball_center_q;
    assign gameState  = state_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign gameOver   = game_over_q;

endmodule
